route_dispatch: RTL and testbench

//   Receive end of the x_y routing stage: accepts modified-header flits {route[1:0], header},

---
 rtl/route_dispatch.sv | 101 ++++++++++
 tb/tb_route_dispatch.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/route_dispatch.sv
// route_dispatch
//   Receive end of the x_y routing stage. Flits arrive as {route[1:0], header}
//   and wait in a small FIFO. The head entry's route field becomes a one-hot
//   request to one of four output directions. The route field is removed, and
//   the original header is offered to the requested direction.
//
// Ports
//   clk        in   rising-edge clock
//   reset      in   synchronous, active-high; clears all buffered flits
//   in_valid   in   upstream flit valid
//   in_ready   out  buffer can accept a flit (not full, not in reset)
//   in_flit    in   {route, header} from the routing stage
//   out_valid  out  one-hot request: bit0 north, 1 east, 2 south, 3 west
//   out_ready  in   per-direction accept; only the requested bit matters
//   out_header out  head flit with route stripped, shared by all directions
//   count      out  number of entries currently held (0..FIFO_DEPTH)
module route_dispatch #(
  parameter int HEADER_SIZE          = 4,
  parameter int MODIFIED_HEADER_SIZE = 6,
  parameter int FIFO_DEPTH           = 4,
  parameter int PTR_WIDTH            = 2
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [MODIFIED_HEADER_SIZE-1:0] in_flit,
  output logic [3:0]                      out_valid,
  input  logic [3:0]                      out_ready,
  output logic [HEADER_SIZE-1:0]          out_header,
  output logic [PTR_WIDTH:0]              count
);

  logic [MODIFIED_HEADER_SIZE-1:0] r_mem [FIFO_DEPTH];
  logic [PTR_WIDTH-1:0]            r_rd_ptr;
  logic [PTR_WIDTH-1:0]            r_wr_ptr;
  logic [PTR_WIDTH:0]              r_count;

  logic                            w_full;
  logic                            w_empty;
  logic                            w_push;
  logic                            w_pop;
  logic [MODIFIED_HEADER_SIZE-1:0] w_head;
  logic [1:0]                      w_route;

  assign w_full  = (r_count == (PTR_WIDTH+1)'(FIFO_DEPTH));
  assign w_empty = (r_count == '0);
  assign w_head  = r_mem[r_rd_ptr];
  assign w_route = w_head[MODIFIED_HEADER_SIZE-1 -: 2];

  // in_ready depends only on registered state and reset. A pop in the same
  // cycle never frees a slot for a push in that cycle.
  assign in_ready = ~w_full & ~reset;
  assign w_push   = in_valid & in_ready;
  assign w_pop    = |(out_valid & out_ready);
  assign count    = r_count;

  always_comb begin
    out_valid  = '0;
    out_header = '0;
    if (!w_empty) begin
      out_header = w_head[HEADER_SIZE-1:0];
      case (w_route)
        2'b00:   out_valid = 4'b0001;
        2'b01:   out_valid = 4'b0010;
        2'b10:   out_valid = 4'b0100;
        default: out_valid = 4'b1000;
      endcase
    end
  end

  // Storage has no reset. Stale contents are never visible because the
  // outputs are masked while the buffer is empty. A push only goes to a free
  // slot, so the head entry stays stable until it is popped.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= in_flit;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: tb/tb_route_dispatch.sv
module tb_route_dispatch;
  localparam int H = 4;
  localparam int M = 6;
  localparam int D = 4;
  localparam int P = 2;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [M-1:0] in_flit;
  logic [3:0]   out_valid;
  logic [3:0]   out_ready;
  logic [H-1:0] out_header;
  logic [P:0]   count;

  int checks = 0;
  int errors = 0;
  logic [M-1:0] sb[$];

  typedef struct {
    logic       v;
    logic [5:0] f;
    logic [3:0] rdy;
    logic [3:0] ev;
    logic [3:0] eh;
    int         ec;
  } vec_t;
  vec_t vecs[15];

  route_dispatch #(
    .HEADER_SIZE(H),
    .MODIFIED_HEADER_SIZE(M),
    .FIFO_DEPTH(D),
    .PTR_WIDTH(P)
  ) dut (
    .clk(clk),
    .reset(reset),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_flit(in_flit),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_header(out_header),
    .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare the DUT outputs with the scoreboard queue.
  task automatic model_check();
    logic [3:0]   ev;
    logic [H-1:0] eh;
    logic [1:0]   r;
    ev = '0;
    eh = '0;
    if (sb.size() != 0) begin
      r  = sb[0][M-1 -: 2];
      ev = 4'b0001 << r;
      eh = sb[0][H-1:0];
    end
    chk("count", 32'(count), sb.size());
    chk("in_ready", 32'(in_ready), 32'(sb.size() < D));
    chk("out_valid", 32'(out_valid), 32'(ev));
    chk("out_header", 32'(out_header), 32'(eh));
  endtask

  // Drive one cycle of stimulus, update the scoreboard from what was driven,
  // then check at the following negedge.
  task automatic step(input logic v, input logic [M-1:0] f, input logic [3:0] rdy);
    logic       push;
    logic       pop;
    logic [1:0] r;
    in_valid  = v;
    in_flit   = f;
    out_ready = rdy;
    @(posedge clk);
    push = v && (sb.size() < D);
    pop  = 1'b0;
    if (sb.size() != 0) begin
      r   = sb[0][M-1 -: 2];
      pop = rdy[r];
    end
    if (pop) void'(sb.pop_front());
    if (push) sb.push_back(f);
    @(negedge clk);
    model_check();
  endtask

  initial begin
    logic [M-1:0] f;

    vecs[0]  = '{1'b1, 6'b01_1010, 4'b1111, 4'b0010, 4'b1010, 1};
    vecs[1]  = '{1'b0, 6'b00_0000, 4'b1111, 4'b0000, 4'b0000, 0};
    vecs[2]  = '{1'b1, 6'b00_0001, 4'b0000, 4'b0001, 4'b0001, 1};
    vecs[3]  = '{1'b1, 6'b01_0010, 4'b0000, 4'b0001, 4'b0001, 2};
    vecs[4]  = '{1'b1, 6'b10_0100, 4'b0000, 4'b0001, 4'b0001, 3};
    vecs[5]  = '{1'b1, 6'b11_1000, 4'b0000, 4'b0001, 4'b0001, 4};
    vecs[6]  = '{1'b1, 6'b00_1111, 4'b0000, 4'b0001, 4'b0001, 4};
    vecs[7]  = '{1'b0, 6'b00_0000, 4'b1111, 4'b0010, 4'b0010, 3};
    vecs[8]  = '{1'b0, 6'b00_0000, 4'b1111, 4'b0100, 4'b0100, 2};
    vecs[9]  = '{1'b0, 6'b00_0000, 4'b1111, 4'b1000, 4'b1000, 1};
    vecs[10] = '{1'b0, 6'b00_0000, 4'b1111, 4'b0000, 4'b0000, 0};
    vecs[11] = '{1'b1, 6'b10_0110, 4'b1011, 4'b0100, 4'b0110, 1};
    vecs[12] = '{1'b0, 6'b00_0000, 4'b1011, 4'b0100, 4'b0110, 1};
    vecs[13] = '{1'b0, 6'b00_0000, 4'b1011, 4'b0100, 4'b0110, 1};
    vecs[14] = '{1'b0, 6'b00_0000, 4'b0100, 4'b0000, 4'b0000, 0};

    reset     = 1'b1;
    in_valid  = 1'b0;
    in_flit   = '0;
    out_ready = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    model_check();

    // Reset with flits buffered and a push offered in the reset cycle.
    step(1'b1, 6'b00_0011, 4'b0000);
    step(1'b1, 6'b01_0101, 4'b0000);
    step(1'b1, 6'b10_0111, 4'b0000);
    reset    = 1'b1;
    in_valid = 1'b1;
    in_flit  = 6'b11_1100;
    #1;
    chk("in_ready_during_reset", 32'(in_ready), 32'd0);
    @(posedge clk);
    sb.delete();
    @(negedge clk);
    reset    = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("reset_count", 32'(count), 32'd0);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    chk("reset_out_header", 32'(out_header), 32'd0);
    model_check();

    // Directed vectors: single flit, fill/drain in order, stall on one direction.
    for (int i = 0; i < 15; i++) begin
      step(vecs[i].v, vecs[i].f, vecs[i].rdy);
      chk($sformatf("vec%0d_out_valid", i), 32'(out_valid), 32'(vecs[i].ev));
      chk($sformatf("vec%0d_out_header", i), 32'(out_header), 32'(vecs[i].eh));
      chk($sformatf("vec%0d_count", i), 32'(count), vecs[i].ec);
      chk($sformatf("vec%0d_in_ready", i), 32'(in_ready), 32'(vecs[i].ec != D));
    end

    // Full FIFO, then continuous push+pop: one stall cycle, then steady at D-1.
    for (int i = 0; i < D; i++) begin
      f = M'(i * 17 + 5);
      step(1'b1, f, 4'b0000);
    end
    chk("full_in_ready", 32'(in_ready), 32'd0);
    step(1'b1, 6'b11_0000, 4'b1111);
    chk("full_pop_count", 32'(count), D - 1);
    for (int i = 0; i < 3 * D; i++) begin
      f = M'(i * 7 + 3);
      step(1'b1, f, 4'b1111);
      chk("steady_count", 32'(count), D - 1);
    end
    for (int i = 0; i < D; i++) step(1'b0, '0, 4'b1111);
    chk("drained_count", 32'(count), 32'd0);

    // Random traffic against the scoreboard.
    for (int i = 0; i < 1000; i++) begin
      step(1'($urandom_range(0, 1)), M'($urandom), 4'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
